// File: rtl/arm_multicycle_ctrl.sv
// Main control FSM for the multicycle ARMv4-subset core.
// Sequences fetch/decode/execute over a shared memory, owns the NZCV
// flags and the condition check, stretches memory states while the
// memory is not ready, and aborts a hung access after TIMEOUT cycles.
module arm_multicycle_ctrl #(
    parameter int unsigned TIMEOUT     = 16,
    parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ImmSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUControl,
    output logic [1:0]  ResultSrc,
    output logic [3:0]  Flags,
    output logic        bus_error,
    output logic        illegal,
    output logic [3:0]  state
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;

    // Counter must be able to hold the value TIMEOUT itself.
    localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    // ARM condition-code table; cond 1111 never executes here.
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic ok;
        {n, z, c, v} = nzcv;
        case (cond)
            4'b0000: ok = z;
            4'b0001: ok = ~z;
            4'b0010: ok = c;
            4'b0011: ok = ~c;
            4'b0100: ok = n;
            4'b0101: ok = ~n;
            4'b0110: ok = v;
            4'b0111: ok = ~v;
            4'b1000: ok = c & ~z;
            4'b1001: ok = ~c | z;
            4'b1010: ok = (n == v);
            4'b1011: ok = (n != v);
            4'b1100: ok = ~z & (n == v);
            4'b1101: ok = z | (n != v);
            4'b1110: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // DP opcode to ALU operation; unsupported opcodes fall back to ADD.
    function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
        logic [1:0] ctl;
        case (cmd)
            4'b0100: ctl = 2'b00;
            4'b0010: ctl = 2'b01;
            4'b0000: ctl = 2'b10;
            4'b1100: ctl = 2'b11;
            default: ctl = 2'b00;
        endcase
        return ctl;
    endfunction

    // Instr holds bits 31:12 of the instruction word.
    logic [3:0] cond_s;
    logic [1:0] op_s;
    logic       i_bit_s;
    logic [3:0] cmd_s;
    logic       s_bit_s;
    logic [3:0] rd_s;
    logic       unused_rn_s;

    assign cond_s      = Instr[19:16];
    assign op_s        = Instr[15:14];
    assign i_bit_s     = Instr[13];
    assign cmd_s       = Instr[12:9];
    assign s_bit_s     = Instr[8];   // S for data-processing, L for memory
    assign rd_s        = Instr[3:0];
    assign unused_rn_s = ^Instr[7:4];

    logic [3:0]       state_q, state_d;
    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic       cond_ex_s;
    logic [1:0] alu_ctrl_s;
    logic       waiting_s;
    logic       timeout_s;

    assign cond_ex_s  = cond_check(cond_s, flags_q);
    assign alu_ctrl_s = alu_decode(cmd_s);
    assign waiting_s  = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    // A completing access in the limit cycle is not aborted.
    assign timeout_s  = (TIMEOUT != 0) && waiting_s && !mem_ready && (wait_cnt_q == CNT_LIMIT);

    logic       pc_write_s, ir_write_s, reg_write_s, mem_write_s;
    logic       adr_src_s, alu_src_a_s, bus_error_s, illegal_s;
    logic [1:0] reg_src_s, imm_src_s, alu_src_b_s, alu_control_s, result_src_s;

    // Next-state, Moore output decode, flag update and wait-counter logic.
    always_comb begin
        state_d       = state_q;
        flags_d       = flags_q;
        wait_cnt_d    = wait_cnt_q;
        pc_write_s    = 1'b0;
        ir_write_s    = 1'b0;
        reg_write_s   = 1'b0;
        mem_write_s   = 1'b0;
        adr_src_s     = 1'b0;
        alu_src_a_s   = 1'b0;
        reg_src_s     = 2'b00;
        imm_src_s     = 2'b00;
        alu_src_b_s   = 2'b00;
        alu_control_s = 2'b00;
        result_src_s  = 2'b00;
        illegal_s     = 1'b0;
        bus_error_s   = timeout_s;

        case (state_q)
            S_FETCH: begin
                // PC <= PC + 4 while the instruction is latched
                alu_src_a_s  = 1'b1;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                if (mem_ready) begin
                    pc_write_s = 1'b1;
                    ir_write_s = 1'b1;
                    state_d    = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                // ALU computes PC+8 so it can be read back as R15
                alu_src_a_s  = 1'b1;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                reg_src_s    = {(op_s == 2'b01) && !s_bit_s, op_s == 2'b10};
                if (!cond_ex_s) begin
                    state_d = S_FETCH;
                end else begin
                    case (op_s)
                        2'b00:   state_d = i_bit_s ? S_EXECI : S_EXECR;
                        2'b01:   state_d = S_MEMADR;
                        2'b10:   state_d = S_BRANCH;
                        default: begin
                            state_d   = S_FETCH;
                            illegal_s = 1'b1;
                        end
                    endcase
                end
            end
            S_MEMADR: begin
                alu_src_b_s   = 2'b01;
                imm_src_s     = 2'b01;
                alu_control_s = 2'b00;
                state_d       = s_bit_s ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                adr_src_s = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout_s) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEMRD;
                end
            end
            S_MEMWR: begin
                adr_src_s = 1'b1;
                reg_src_s = 2'b10;
                if (mem_ready) begin
                    mem_write_s = 1'b1;
                    state_d     = S_FETCH;
                end else if (timeout_s) begin
                    mem_write_s = 1'b0;
                    state_d     = S_FETCH;
                end else begin
                    mem_write_s = 1'b1;
                    state_d     = S_MEMWR;
                end
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                if (rd_s == 4'd15) begin
                    pc_write_s = 1'b1;
                end else begin
                    reg_write_s = 1'b1;
                end
                state_d = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                alu_src_b_s   = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                imm_src_s     = 2'b00;
                alu_control_s = alu_ctrl_s;
                if (s_bit_s) begin
                    flags_d[3:2] = ALUFlags[3:2];
                    // C and V are only meaningful for the adder
                    if (!alu_ctrl_s[1]) begin
                        flags_d[1:0] = ALUFlags[1:0];
                    end else begin
                        flags_d[1:0] = flags_q[1:0];
                    end
                end else begin
                    flags_d = flags_q;
                end
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                result_src_s = 2'b00;
                if (rd_s == 4'd15) begin
                    pc_write_s = 1'b1;
                end else begin
                    reg_write_s = 1'b1;
                end
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                reg_src_s    = 2'b01;
                alu_src_b_s  = 2'b01;
                imm_src_s    = 2'b10;
                result_src_s = 2'b10;
                pc_write_s   = 1'b1;
                state_d      = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (timeout_s || mem_ready || !waiting_s || (state_d != state_q)) begin
            wait_cnt_d = CNT_ZERO;
        end else if (TIMEOUT != 0) begin
            wait_cnt_d = wait_cnt_q + CNT_ONE;
        end else begin
            wait_cnt_d = CNT_ZERO;
        end
    end

    // State, flag and wait-counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            flags_q    <= RESET_FLAGS;
            wait_cnt_q <= CNT_ZERO;
        end else begin
            state_q    <= state_d;
            flags_q    <= flags_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Enables and pulses drop the instant reset asserts, not at the next edge.
    assign PCWrite    = reset & pc_write_s;
    assign IRWrite    = reset & ir_write_s;
    assign RegWrite   = reset & reg_write_s;
    assign MemWrite   = reset & mem_write_s;
    assign bus_error  = reset & bus_error_s;
    assign illegal    = reset & illegal_s;
    assign AdrSrc     = adr_src_s;
    assign RegSrc     = reg_src_s;
    assign ImmSrc     = imm_src_s;
    assign ALUSrcA    = alu_src_a_s;
    assign ALUSrcB    = alu_src_b_s;
    assign ALUControl = alu_control_s;
    assign ResultSrc  = result_src_s;
    assign Flags      = flags_q;
    assign state      = state_q;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Self-checking bench for arm_multicycle_ctrl: directed test-plan scenarios
// plus randomized instruction streams against an instruction-level model.
module tb_arm_multicycle_ctrl;

    localparam int         TMO       = 16;
    localparam logic [3:0] RST_FLAGS = 4'b0010;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [19:0] instr = 20'd0;
    logic [3:0]  alu_flags = 4'd0;
    logic        mem_ready = 1'b0;
    logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
    logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ALUControl, ResultSrc;
    logic [3:0]  Flags, state;
    logic        bus_error, illegal;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] m_flags;

    arm_multicycle_ctrl #(.TIMEOUT(TMO), .RESET_FLAGS(RST_FLAGS)) dut (
        .clk(clk), .reset(reset), .Instr(instr), .ALUFlags(alu_flags),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
        .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ResultSrc(ResultSrc), .Flags(Flags),
        .bus_error(bus_error), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    logic [21:0] obs_vec;
    assign obs_vec = {state, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
                      ALUSrcB, ALUControl, ResultSrc, ImmSrc, RegSrc, illegal, bus_error};

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] alu_of(input logic [3:0] cmd);
        case (cmd)
            4'b0010: return 2'b01;
            4'b0000: return 2'b10;
            4'b1100: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // Expected control vector for a given step of an instruction.
    function automatic logic [21:0] exp_vec(input int ph, input logic mr,
                                            input logic [31:0] ir, input logic [3:0] fl);
        logic pcw, irw, rw, mw, adr, srca, ill;
        logic [1:0] srcb, aluc, res, imm, rs;
        {pcw, irw, rw, mw, adr, srca, ill} = 7'd0;
        {srcb, aluc, res, imm, rs} = 10'd0;
        case (ph)
            0: begin srca = 1'b1; srcb = 2'd2; res = 2'd2; pcw = mr; irw = mr; end
            1: begin
                srca = 1'b1; srcb = 2'd2; res = 2'd2;
                rs = {(ir[27:26] == 2'b01) && !ir[20], ir[27:26] == 2'b10};
                ill = cond_ok(ir[31:28], fl) && (ir[27:26] == 2'b11);
            end
            2: begin srcb = 2'd1; imm = 2'd1; end
            3: adr = 1'b1;
            4: begin res = 2'd1; if (ir[15:12] == 4'd15) pcw = 1'b1; else rw = 1'b1; end
            5: begin adr = 1'b1; rs = 2'b10; mw = 1'b1; end
            6, 7: begin srcb = (ph == 7) ? 2'd1 : 2'd0; aluc = alu_of(ir[24:21]); end
            8: begin if (ir[15:12] == 4'd15) pcw = 1'b1; else rw = 1'b1; end
            9: begin rs = 2'b01; srcb = 2'd1; imm = 2'd2; res = 2'd2; pcw = 1'b1; end
            default: ;
        endcase
        return {4'(ph), pcw, irw, rw, mw, adr, srca, srcb, aluc, res, imm, rs, ill, 1'b0};
    endfunction

    // Runs one instruction starting just after a negedge with the DUT in FETCH.
    // pct = percent chance memory is ready per wait cycle; stall_rd forces
    // that many not-ready cycles at the start of the load read.
    task automatic run_instr(input logic [31:0] ir, input logic [3:0] aluf, input int pct,
                             input int stall_rd, input string name, output int cycles);
        int path[$];
        int ph, zeros, stalls;
        logic mr, ce;
        logic [21:0] ev;
        instr = ir[31:12];
        alu_flags = aluf;
        ce = cond_ok(ir[31:28], m_flags);
        path.push_back(0);
        path.push_back(1);
        if (ce) begin
            case (ir[27:26])
                2'b00: begin path.push_back(ir[25] ? 7 : 6); path.push_back(8); end
                2'b01: begin
                    path.push_back(2);
                    if (ir[20]) begin path.push_back(3); path.push_back(4); end
                    else path.push_back(5);
                end
                2'b10: path.push_back(9);
                default: ;
            endcase
        end
        cycles = 0;
        foreach (path[k]) begin
            ph = path[k];
            zeros = 0;
            stalls = (ph == 3) ? stall_rd : 0;
            for (int c = 0; c < 64; c++) begin
                if (ph == 0 || ph == 3 || ph == 5) begin
                    if (stalls > 0) begin mr = 1'b0; stalls--; end
                    else if (zeros < 4 && int'($urandom_range(99)) >= pct) begin mr = 1'b0; zeros++; end
                    else mr = 1'b1;
                end else begin
                    mr = 1'($urandom_range(1));
                end
                mem_ready = mr;
                #1;
                ev = exp_vec(ph, mr, ir, m_flags);
                n_cmp++;
                if (obs_vec !== ev) begin
                    n_err++;
                    $display("FAIL %s ir=%h cyc%0d: got %h need %h", name, ir, cycles, obs_vec, ev);
                end
                @(negedge clk);
                cycles++;
                if (!(ph == 0 || ph == 3 || ph == 5) || mr) break;
            end
        end
        if (ce && ir[27:26] == 2'b00 && ir[20]) begin
            m_flags[3:2] = aluf[3:2];
            if (ir[24:21] == 4'b0100 || ir[24:21] == 4'b0010) m_flags[1:0] = aluf[1:0];
        end
        n_cmp++;
        if (Flags !== m_flags) begin
            n_err++;
            $display("FAIL %s flags: got %b need %b", name, Flags, m_flags);
        end
    endtask

    task automatic check_cycles(input string name, input int got, input int need);
        n_cmp++;
        if (got !== need) begin
            n_err++;
            $display("FAIL %s cycles: got %0d need %0d", name, got, need);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({state, Flags, PCWrite, IRWrite, RegWrite, MemWrite, bus_error, illegal} !==
            {4'd0, RST_FLAGS, 6'd0}) begin
            n_err++;
            $display("FAIL reset: got st=%0d fl=%b en=%b%b%b%b%b%b need st=0 fl=%b en=0",
                     state, Flags, PCWrite, IRWrite, RegWrite, MemWrite, bus_error, illegal, RST_FLAGS);
        end
        @(negedge clk);
        reset = 1'b1;
        m_flags = RST_FLAGS;
    endtask

    task automatic test_plan_directed();
        int cyc;
        run_instr(32'hE2801005, 4'b1111, 100, 0, "add_imm", cyc);
        check_cycles("add_imm", cyc, 4);
        run_instr(32'hE0512001, 4'b0100, 100, 0, "subs", cyc);
        check_cycles("subs", cyc, 4);
        run_instr(32'h0A000001, 4'b0000, 100, 0, "beq_taken", cyc);
        check_cycles("beq_taken", cyc, 3);
        run_instr(32'hE2911001, 4'b0000, 100, 0, "adds_clr", cyc);
        run_instr(32'h0A000001, 4'b0000, 100, 0, "beq_not", cyc);
        check_cycles("beq_not", cyc, 2);
        run_instr(32'hE5903008, 4'b0000, 100, 3, "ldr_wait", cyc);
        check_cycles("ldr_wait", cyc, 8);
        run_instr(32'hE5803064, 4'b0000, 100, 0, "str", cyc);
        check_cycles("str", cyc, 4);
        run_instr(32'hEC000000, 4'b0000, 100, 0, "illegal", cyc);
        check_cycles("illegal", cyc, 2);
        // ready arriving in the very cycle the limit is reached wins
        run_instr(32'hE5903008, 4'b0000, 100, TMO, "ldr_ready_at_limit", cyc);
        check_cycles("ldr_ready_at_limit", cyc, 5 + TMO);
    endtask

    task automatic test_timeout();
        int mw_cnt = 0, be_cnt = 0, be_mw = 0;
        logic back = 1'b0;
        instr = 20'hE5803;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (state == 4'd0) begin back = 1'b1; break; end
            if (state == 4'd5 && MemWrite) mw_cnt++;
            if (bus_error) begin be_cnt++; if (MemWrite) be_mw++; end
            @(negedge clk);
        end
        n_cmp++;
        if (!back) begin n_err++; $display("FAIL timeout_return: got no FETCH need state 0"); end
        n_cmp++;
        if (mw_cnt != TMO) begin n_err++; $display("FAIL timeout_memwrite: got %0d need %0d", mw_cnt, TMO); end
        n_cmp++;
        if (be_cnt != 1) begin n_err++; $display("FAIL timeout_pulse: got %0d need 1", be_cnt); end
        n_cmp++;
        if (be_mw != 0) begin n_err++; $display("FAIL timeout_we: got %0d need 0", be_mw); end
        @(negedge clk);
        mem_ready = 1'b1;
    endtask

    task automatic test_reset_in_memwr();
        int cyc;
        run_instr(32'hE0512001, 4'b1101, 100, 0, "subs_pre", cyc);
        instr = 20'hE5803;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #1;
        n_cmp++;
        if ({state, MemWrite} !== {4'd5, 1'b1}) begin
            n_err++;
            $display("FAIL memwr_pre: got st=%0d mw=%b need st=5 mw=1", state, MemWrite);
        end
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if ({state, MemWrite, Flags} !== {4'd0, 1'b0, RST_FLAGS}) begin
            n_err++;
            $display("FAIL async_reset: got st=%0d mw=%b fl=%b need st=0 mw=0 fl=%b",
                     state, MemWrite, Flags, RST_FLAGS);
        end
        mem_ready = 1'b1;
        #1;
        n_cmp++;
        if ({PCWrite, IRWrite} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_fetch_en: got %b%b need 00", PCWrite, IRWrite);
        end
        @(negedge clk);
        reset = 1'b1;
        m_flags = RST_FLAGS;
    endtask

    task automatic test_random(input int n);
        logic [3:0] cmd_tab [6] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b1101};
        logic [31:0] ir;
        logic [3:0] cond, cmd, rd;
        logic [1:0] op;
        logic bit20;
        int ci, cyc;
        for (int i = 0; i < n; i++) begin
            cond = ($urandom_range(2) == 0) ? 4'($urandom_range(15)) : 4'hE;
            op   = 2'($urandom_range(3));
            ci   = $urandom_range(5);
            cmd  = cmd_tab[ci];
            bit20 = 1'($urandom_range(1));
            if (op == 2'b00 && ci > 3) bit20 = 1'b0;
            rd = ($urandom_range(3) == 0) ? 4'd15 : 4'($urandom_range(15));
            ir = {cond, op, 1'($urandom_range(1)), cmd, bit20, 4'($urandom_range(15)), rd,
                  12'($urandom_range(4095))};
            run_instr(ir, 4'($urandom_range(15)), 75, 0, "random", cyc);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish need finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_flags = RST_FLAGS;
        test_reset();
        test_plan_directed();
        test_timeout();
        test_reset_in_memwr();
        test_random(300);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arm_multicycle_ctrl.md
Name: arm_multicycle_ctrl

Overview:
Main control FSM that sequences a multicycle version of the ARMv4-subset core. The core uses one shared instruction/data memory, one ALU reused for PC increment and address calculation, and instruction/ALUOut/data registers.
The block owns the condition flags and the condition check, and holds the datapath while memory is not ready. A bus timeout aborts a hung access.
It replaces the single-cycle controller. The register file, extender, ALU and memory interface are reused unchanged.

Parameters:
TIMEOUT, 16, cycles a memory access may wait for mem_ready before abort; 0 disables the timeout.
RESET_FLAGS, 4'b0000, value of {N,Z,C,V} after reset.

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset)
Instr  in  20  Instr[31:12] from instruction register
ALUFlags  in  4  {N,Z,C,V} from ALU, combinational
mem_ready  in  1  memory has completed the current access this cycle
PCWrite  out  1  PC register enable
IRWrite  out  1  instruction register enable
RegWrite  out  1  register file write enable
MemWrite  out  1  memory write strobe
AdrSrc  out  1  memory address mux: 0 = PC, 1 = ALUOut
RegSrc  out  2  [0]: RA1 = R15; [1]: RA2 = Rd
ImmSrc  out  2  extender mode: 00 imm8, 01 imm12, 10 branch
ALUSrcA  out  1  0 = register A, 1 = PC
ALUSrcB  out  2  00 = register B, 01 = ExtImm, 10 = constant 4
ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALU direct
Flags  out  4  current {N,Z,C,V}
bus_error  out  1  one-cycle pulse when an access is aborted by timeout
illegal  out  1  one-cycle pulse in DECODE when op = 11
state  out  4  current state encoding, for debug

Behaviour:
- States and encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Encodings 10-15 are unreachable; if entered, next state = FETCH.
- Reset while reset=0, at any time including mid-access:
  - state = FETCH, Flags = RESET_FLAGS, wait counter = 0.
  - PCWrite, IRWrite, RegWrite, MemWrite, bus_error and illegal are forced to 0.
- Outputs are Moore, decoded from state, except where a term is gated by mem_ready or Rd. Unlisted selects = 0.
- FETCH:
  - Drives AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10.
  - IRWrite = PCWrite = mem_ready.
  - mem_ready=1 -> DECODE; otherwise stay in FETCH.
- DECODE:
  - Drives ALUSrcA=1, ALUSrcB=10, ResultSrc=10, so PC+8 is available as R15.
  - RegSrc = {op==01 & L==0, op==10}.
  - CondEx is evaluated from Instr[31:28] and Flags using the standard 15-code table; cond 1111 gives CondEx = 0.
  - CondEx=0 -> FETCH; the instruction is a NOP.
  - CondEx=1: op 00 -> EXECI if Instr[25]=1, else EXECR; op 01 -> MEMADR; op 10 -> BRANCH; op 11 -> FETCH with illegal=1.
- MEMADR: drives ALUSrcB=01, ImmSrc=01, ALUControl=00. Next state MEMRD if L=1, else MEMWR.
- MEMRD: drives AdrSrc=1. mem_ready -> MEMWB.
- MEMWR: drives AdrSrc=1, RegSrc[1]=1, MemWrite=1, held until mem_ready. mem_ready -> FETCH.
- MEMWB:
  - Drives ResultSrc=01.
  - Rd==15 -> PCWrite=1; otherwise RegWrite=1.
  - Next state FETCH.
- EXECR / EXECI:
  - ALUSrcB = 00 in EXECR, 01 in EXECI; ImmSrc=00.
  - ALUControl from Instr[24:21]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR. Any other code decodes as ADD.
  - If S=1, Flags[3:2] <= ALUFlags[3:2] at the end of this state.
  - Flags[1:0] are updated only for ADD/SUB.
  - Next state ALUWB.
- ALUWB: drives ResultSrc=00. Rd==15 -> PCWrite=1; otherwise RegWrite=1. Next state FETCH.
- BRANCH: drives RegSrc[0]=1, ALUSrcB=01, ImmSrc=10, ResultSrc=10, PCWrite=1. Next state FETCH.
- Cycles per instruction with mem_ready held at 1:
  - failed condition / illegal: 2
  - B: 3
  - DP: 4
  - STR: 4
  - LDR: 5
- Wait counter:
  - Counts consecutive cycles in FETCH, MEMRD or MEMWR with mem_ready=0.
  - Clears on mem_ready=1 or on any state change.
  - If TIMEOUT>0 and the counter reaches TIMEOUT: bus_error=1 for one cycle, next state FETCH, no write enables asserted, counter cleared.
  - mem_ready=1 on the same cycle as the timeout wins over the timeout.

Test Plan:
- Reset release, mem_ready=1, IR=E2801005 (ADD R1,R0,#5) -> state sequence 0,1,7,8,0. RegWrite=1 only in ALUWB. PCWrite=1 only in FETCH. Flags unchanged.
- IR=E0512001 (SUBS R2,R1,R1) -> in EXECR ALUControl=01. On leaving EXECR with ALUFlags=0100, Flags=0100.
- With Flags Z=1, IR=0A000001 (BEQ) -> states 0,1,9,0 with PCWrite in BRANCH. With Z=0 -> states 0,1,0 and no PCWrite outside FETCH.
- IR=E5903008 (LDR), mem_ready=0 for 3 cycles in MEMRD -> state held at 3, then 4. RegWrite=1 in MEMWB. Total 8 cycles.
- IR=E5803064 (STR), mem_ready stuck at 0, TIMEOUT=16 -> MemWrite high for 16 cycles, bus_error pulses once, state returns to 0.
- Reset driven to 0 in MEMWR with MemWrite=1 -> MemWrite drops to 0 immediately, without waiting for clk. state=0, Flags=RESET_FLAGS.
